shade_write_arbiter: RTL and testbench
======================================

Name: shade_write_arbiter

Overview:
Shares the single framebuffer memory write port among NUM_CORES ray cores. Each core pushes shaded pixels (address + colour) into a private FIFO. A round-robin arbiter drains the FIFOs into one registered valid/ready write request toward the memory controller. The block also counts committed pixels per frame and flags frame completion to the top-level render state machine.

Parameters:
NUM_CORES, 4, number of ray cores (requesters), 2..8
ADDR_WIDTH, 17, framebuffer word address width
DATA_WIDTH, 24, pixel colour width (RGB888)
FIFO_DEPTH, 4, per-core FIFO entries; power of two, >= 4
FRAME_PIXELS, 76800, committed pixels that complete one frame

Ports:
clk  in  1  system clock
resetn  in  1  asynchronous active-low reset
frame_reset  in  1  synchronous clear at frame setup
core_valid  in  NUM_CORES  per-core push strobe
core_addr  in  NUM_CORES*ADDR_WIDTH  per-core pixel address; core i at bits [i*ADDR_WIDTH +: ADDR_WIDTH]
core_data  in  NUM_CORES*DATA_WIDTH  per-core colour; same packing as core_addr
core_full  out  NUM_CORES  per-core almost-full backpressure
overflow  out  NUM_CORES  sticky: a push was dropped
mem_w_valid  out  1  write request valid
mem_w_addr  out  ADDR_WIDTH  write address
mem_w_data  out  DATA_WIDTH  write data
mem_w_ready  in  1  memory accepts request
pixel_total  out  32  pixels committed since last frame_reset
frame_done  out  1  sticky: pixel_total reached FRAME_PIXELS

Behaviour:
- Reset (resetn low, async): all FIFOs empty; core_full=0; overflow=0; mem_w_valid=0; mem_w_addr=0; mem_w_data=0; pixel_total=0; frame_done=0; round-robin pointer=0.
- frame_reset (sampled at posedge) produces the same clear as resetn, except it is synchronous. It has priority over any push, pop or handshake in the same cycle.
- FIFO push: core_valid[i] high writes {addr, data} into FIFO i at the clock edge.
  - If FIFO i is full, the entry is dropped and overflow[i] sets. overflow[i] stays set until reset or frame_reset.
- core_full[i] = (count_i >= FIFO_DEPTH-1). Registered, so cores get one cycle of slack. A push issued in the same cycle as core_full rising must still fit.
- Push and pop on the same FIFO in the same cycle are both allowed; the count is unchanged.
- Output register: one entry.
  - While mem_w_valid=1 and mem_w_ready=0, mem_w_addr and mem_w_data stay stable.
  - The register may load when it is empty, or when it is being consumed this cycle (mem_w_valid && mem_w_ready). This gives full throughput of one write per cycle.
- Arbitration (combinational, same cycle as load):
  - Search nonempty FIFOs starting at index ptr+1 modulo NUM_CORES and grant the first one found.
  - Pop the granted FIFO, load its head into the output register, set ptr=grant.
  - If no FIFO is nonempty, ptr is unchanged and mem_w_valid deasserts after a consume.
- Latency: core_valid at cycle t into an empty, idle arbiter gives mem_w_valid=1 in cycle t+2.
- Fairness: with all FIFOs continuously nonempty and ready=1, grants rotate 0,1,..,N-1,0. No core waits more than NUM_CORES grants.
- Commit counting:
  - pixel_total increments by 1 on each mem_w_valid && mem_w_ready.
  - At 2^32-1 it wraps to 0.
- frame_done is registered.
  - It sets in the cycle after pixel_total becomes >= FRAME_PIXELS and stays set until reset or frame_reset.
  - Commits after frame_done keep counting.
- frame_reset mid-transfer: a pending mem_w_valid is withdrawn in the next cycle even if ready=0. Any queued pixels are discarded.

Test Plan:
- Single core: core_valid[2] for 1 cycle with addr=0x00010, data=0xFF8000, ready=1. Required: mem_w_valid high exactly at t+2 with those values; pixel_total=1 after the handshake.
- All 4 cores push 1 pixel in the same cycle, ready=1, ptr=0 after reset. Required: writes from cores 1,2,3,0 on 4 consecutive cycles; pixel_total=4.
- Backpressure: core 0 pushes 3 pixels while ready=0. Required: mem_w_valid held with addr/data stable; core_full[0] high after count reaches 3.
  - A 4th push is accepted; a 5th sets overflow[0].
  - Release ready: 4 writes are issued, in order.
- Throughput: core 1 pushes every cycle for 20 cycles, ready=1. Required: 20 back-to-back writes with no bubble after the first; core_full[1] never asserts.
- Frame completion with FRAME_PIXELS=8: commit 8 pixels. Required: frame_done rises 1 cycle after the 8th handshake.
  - Then assert frame_reset with 2 entries queued and ready=0. Required: next cycle mem_w_valid=0, pixel_total=0, frame_done=0, FIFOs empty.
- Async reset mid-stream: drop resetn asynchronously while ready=0. Required: all outputs go to their reset values immediately, with no clock edge needed.

Source files
------------

// File: rtl/shade_write_if.sv
// shade_write_if: core push side and framebuffer write side of the shade
// write arbiter, plus frame bookkeeping. "master" is the arbiter's view and
// "slave" is the view of the environment (ray cores + memory controller).
interface shade_write_if #(
  parameter int NUM_CORES  = 4,
  parameter int ADDR_WIDTH = 17,
  parameter int DATA_WIDTH = 24
);
  logic                            frame_reset;
  logic [NUM_CORES-1:0]            core_valid;
  logic [NUM_CORES*ADDR_WIDTH-1:0] core_addr;
  logic [NUM_CORES*DATA_WIDTH-1:0] core_data;
  logic [NUM_CORES-1:0]            core_full;
  logic [NUM_CORES-1:0]            overflow;
  logic                            mem_w_valid;
  logic [ADDR_WIDTH-1:0]           mem_w_addr;
  logic [DATA_WIDTH-1:0]           mem_w_data;
  logic                            mem_w_ready;
  logic [31:0]                     pixel_total;
  logic                            frame_done;

  modport master (
    input  frame_reset, core_valid, core_addr, core_data, mem_w_ready,
    output core_full, overflow, mem_w_valid, mem_w_addr, mem_w_data,
           pixel_total, frame_done
  );

  modport slave (
    output frame_reset, core_valid, core_addr, core_data, mem_w_ready,
    input  core_full, overflow, mem_w_valid, mem_w_addr, mem_w_data,
           pixel_total, frame_done
  );
endinterface

// File: rtl/shade_write_arbiter.sv
// shade_write_arbiter: per-core pixel FIFOs drained round-robin into a single
// registered framebuffer write request; counts committed pixels per frame.
module shade_write_arbiter #(
  parameter int NUM_CORES    = 4,
  parameter int ADDR_WIDTH   = 17,
  parameter int DATA_WIDTH   = 24,
  parameter int FIFO_DEPTH   = 4,
  parameter int FRAME_PIXELS = 76800
) (
  input logic          clk,
  input logic          resetn,
  shade_write_if.master bus
);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int IDX_W = $clog2(NUM_CORES);
  localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] ALMOST_C = CNT_W'(FIFO_DEPTH - 1);
  localparam logic [31:0]      FRAME_C  = 32'(FRAME_PIXELS);

  logic [ADDR_WIDTH-1:0] fifo_addr [NUM_CORES][FIFO_DEPTH];
  logic [DATA_WIDTH-1:0] fifo_data [NUM_CORES][FIFO_DEPTH];
  logic [PTR_W-1:0]      wr_ptr    [NUM_CORES];
  logic [PTR_W-1:0]      rd_ptr    [NUM_CORES];
  logic [CNT_W-1:0]      count     [NUM_CORES];
  logic [CNT_W-1:0]      count_nxt [NUM_CORES];

  logic [NUM_CORES-1:0]  push_ok, pop, core_full_q, overflow_q;
  logic [IDX_W-1:0]      rr_ptr, grant_idx, cand;
  logic                  grant_valid, load_en, consume;
  logic                  out_valid;
  logic [ADDR_WIDTH-1:0] out_addr, head_addr;
  logic [DATA_WIDTH-1:0] out_data, head_data;
  logic [31:0]           pixel_total_q;
  logic                  frame_done_q;

  // The output register refills when empty or when drained this cycle.
  assign consume   = out_valid & bus.mem_w_ready;
  assign load_en   = ~out_valid | bus.mem_w_ready;
  assign head_addr = fifo_addr[grant_idx][rd_ptr[grant_idx]];
  assign head_data = fifo_data[grant_idx][rd_ptr[grant_idx]];

  // Round-robin search beginning one past the last granted core.
  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = rr_ptr;
    cand        = rr_ptr;
    for (int k = 1; k <= NUM_CORES; k++) begin
      cand = IDX_W'((int'(rr_ptr) + k) % NUM_CORES);
      if (!grant_valid && count[cand] != '0) begin
        grant_valid = 1'b1;
        grant_idx   = cand;
      end
    end
  end

  // Per-core push/pop decisions; a full FIFO still accepts when it pops too.
  always_comb begin
    pop     = '0;
    push_ok = '0;
    for (int i = 0; i < NUM_CORES; i++) begin
      pop[i]       = grant_valid && load_en && (grant_idx == IDX_W'(i));
      push_ok[i]   = bus.core_valid[i] && (count[i] != DEPTH_C || pop[i]);
      count_nxt[i] = count[i] + CNT_W'(push_ok[i]) - CNT_W'(pop[i]);
    end
  end

  // FIFO storage; contents are don't-care once the pointers are cleared.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_CORES; i++) begin
      if (push_ok[i]) begin
        fifo_addr[i][wr_ptr[i]] <= bus.core_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
        fifo_data[i][wr_ptr[i]] <= bus.core_data[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // FIFO pointers, occupancy, almost-full and sticky overflow flags.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < NUM_CORES; i++) begin
        wr_ptr[i] <= '0;
        rd_ptr[i] <= '0;
        count[i]  <= '0;
      end
      core_full_q <= '0;
      overflow_q  <= '0;
    end else if (bus.frame_reset) begin
      for (int i = 0; i < NUM_CORES; i++) begin
        wr_ptr[i] <= '0;
        rd_ptr[i] <= '0;
        count[i]  <= '0;
      end
      core_full_q <= '0;
      overflow_q  <= '0;
    end else begin
      for (int i = 0; i < NUM_CORES; i++) begin
        if (push_ok[i]) wr_ptr[i] <= wr_ptr[i] + PTR_W'(1);
        if (pop[i])     rd_ptr[i] <= rd_ptr[i] + PTR_W'(1);
        count[i]       <= count_nxt[i];
        // Asserting at DEPTH-1 leaves room for the push issued this cycle.
        core_full_q[i] <= (count_nxt[i] >= ALMOST_C);
        if (bus.core_valid[i] && !push_ok[i]) overflow_q[i] <= 1'b1;
      end
    end
  end

  // Output request register and round-robin pointer.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      out_valid <= 1'b0;
      out_addr  <= '0;
      out_data  <= '0;
      rr_ptr    <= '0;
    end else if (bus.frame_reset) begin
      out_valid <= 1'b0;
      out_addr  <= '0;
      out_data  <= '0;
      rr_ptr    <= '0;
    end else if (load_en) begin
      out_valid <= grant_valid;
      if (grant_valid) begin
        out_addr <= head_addr;
        out_data <= head_data;
        rr_ptr   <= grant_idx;
      end
    end
  end

  // Commit counter (wraps naturally at 2^32) and sticky frame completion.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      pixel_total_q <= '0;
      frame_done_q  <= 1'b0;
    end else if (bus.frame_reset) begin
      pixel_total_q <= '0;
      frame_done_q  <= 1'b0;
    end else begin
      if (consume) pixel_total_q <= pixel_total_q + 32'd1;
      if (pixel_total_q >= FRAME_C) frame_done_q <= 1'b1;
    end
  end

  assign bus.core_full   = core_full_q;
  assign bus.overflow    = overflow_q;
  assign bus.mem_w_valid = out_valid;
  assign bus.mem_w_addr  = out_addr;
  assign bus.mem_w_data  = out_data;
  assign bus.pixel_total = pixel_total_q;
  assign bus.frame_done  = frame_done_q;
endmodule

// File: tb/tb_shade_write_arbiter.sv
// tb_shade_write_arbiter: directed stimulus, queue-based reference model and
// per-cycle output comparison, plus literal checks on key scenarios.
module tb_shade_write_arbiter;
  localparam int NC = 4;
  localparam int AW = 17;
  localparam int DW = 24;
  localparam int FD = 4;
  localparam int FP = 8;

  logic clk = 1'b0;
  logic resetn = 1'b1;
  int   n_cmp = 0;
  int   n_err = 0;
  int   cyc = 0;
  bit   chk_en = 1'b0;
  bit   seen_full1 = 1'b0;
  int   done_cyc = -1;

  always #5 clk = ~clk;

  shade_write_if #(.NUM_CORES(NC), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  shade_write_arbiter #(
    .NUM_CORES(NC), .ADDR_WIDTH(AW), .DATA_WIDTH(DW),
    .FIFO_DEPTH(FD), .FRAME_PIXELS(FP)
  ) dut (
    .clk(clk),
    .resetn(resetn),
    .bus(bus)
  );

  typedef struct packed {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } pix_t;

  // reference model state
  pix_t          mq [NC][$];
  logic          m_valid;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_data;
  int            m_ptr;
  logic [31:0]   m_total;
  logic          m_done;
  logic [NC-1:0] m_full;
  logic [NC-1:0] m_ovf;

  // committed writes seen on the DUT bus
  logic [AW-1:0] log_addr [$];
  int            log_cyc  [$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [AW-1:0] log_a(input int k);
    return (k < log_addr.size()) ? log_addr[k] : 'x;
  endfunction

  function automatic int log_c(input int k);
    return (k < log_cyc.size()) ? log_cyc[k] : -1000;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < NC; i++) mq[i].delete();
    m_valid = 1'b0; m_addr = '0; m_data = '0; m_ptr = 0;
    m_total = '0; m_done = 1'b0; m_full = '0; m_ovf = '0;
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Reference model: queues per core, one-entry output slot, rotating search.
  initial forever begin
    @(posedge clk or negedge resetn);
    if (!resetn || bus.frame_reset) begin
      model_clear();
    end else begin : step
      int   g;
      bit   ld;
      pix_t p;
      ld = !m_valid || bus.mem_w_ready;
      g  = -1;
      for (int k = 1; k <= NC; k++)
        if (g < 0 && mq[(m_ptr + k) % NC].size() > 0) g = (m_ptr + k) % NC;
      if (m_total >= FP) m_done = 1'b1;
      if (m_valid && bus.mem_w_ready) m_total = m_total + 32'd1;
      if (ld) begin
        if (g >= 0) begin
          p = mq[g].pop_front();
          m_valid = 1'b1; m_addr = p.a; m_data = p.d; m_ptr = g;
        end else begin
          m_valid = 1'b0;
        end
      end
      for (int i = 0; i < NC; i++) begin
        if (bus.core_valid[i]) begin
          if (mq[i].size() < FD) begin
            p.a = bus.core_addr[i*AW +: AW];
            p.d = bus.core_data[i*DW +: DW];
            mq[i].push_back(p);
          end else begin
            m_ovf[i] = 1'b1;
          end
        end
      end
      for (int i = 0; i < NC; i++) m_full[i] = (mq[i].size() >= FD - 1);
    end
  end

  // Every-cycle compare against the model, plus bus logging.
  initial forever begin
    @(negedge clk);
    if (resetn) begin
      if (bus.mem_w_valid && bus.mem_w_ready) begin
        log_addr.push_back(bus.mem_w_addr);
        log_cyc.push_back(cyc);
      end
      if (bus.core_full[1]) seen_full1 = 1'b1;
      if (bus.frame_done && done_cyc < 0) done_cyc = cyc;
      if (chk_en) begin
        chk("mem_w_valid", bus.mem_w_valid, m_valid);
        if (m_valid) begin
          chk("mem_w_addr", bus.mem_w_addr, m_addr);
          chk("mem_w_data", bus.mem_w_data, m_data);
        end
        chk("core_full", bus.core_full, m_full);
        chk("overflow", bus.overflow, m_ovf);
        chk("pixel_total", bus.pixel_total, m_total);
        chk("frame_done", bus.frame_done, m_done);
      end
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push(input int core, input logic [AW-1:0] a, input logic [DW-1:0] d);
    bus.core_valid[core]       = 1'b1;
    bus.core_addr[core*AW +: AW] = a;
    bus.core_data[core*DW +: DW] = d;
  endtask

  task automatic idle();
    bus.core_valid = '0;
  endtask

  task automatic frame_clear();
    bus.frame_reset = 1'b1;
    tick();
    bus.frame_reset = 1'b0;
    log_addr.delete();
    log_cyc.delete();
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_valid"}, bus.mem_w_valid, 1'b0);
    chk({tag, "_addr"},  bus.mem_w_addr, '0);
    chk({tag, "_data"},  bus.mem_w_data, '0);
    chk({tag, "_total"}, bus.pixel_total, 32'd0);
    chk({tag, "_done"},  bus.frame_done, 1'b0);
    chk({tag, "_full"},  bus.core_full, 4'b0000);
    chk({tag, "_ovf"},   bus.overflow, 4'b0000);
  endtask

  initial begin
    int k0;
    bus.frame_reset = 1'b0;
    bus.core_valid  = '0;
    bus.core_addr   = '0;
    bus.core_data   = '0;
    bus.mem_w_ready = 1'b0;
    #2 resetn = 1'b0;
    #10 chk_reset_vals("reset");
    #20 resetn = 1'b1;
    tick();
    chk_en = 1'b1;

    // single core, latency t+2
    bus.mem_w_ready = 1'b1;
    push(2, 17'h00010, 24'hFF8000);
    tick(); idle();
    @(negedge clk) chk("t1_valid_t1", bus.mem_w_valid, 1'b0);
    tick();
    @(negedge clk);
    chk("t1_valid_t2", bus.mem_w_valid, 1'b1);
    chk("t1_addr", bus.mem_w_addr, 17'h00010);
    chk("t1_data", bus.mem_w_data, 24'hFF8000);
    tick();
    @(negedge clk) chk("t1_total", bus.pixel_total, 32'd1);

    // all cores at once, pointer cleared: order 1,2,3,0
    tick(); frame_clear();
    for (int i = 0; i < NC; i++) push(i, AW'(12'h100 + i), DW'(i));
    tick(); idle();
    tick(6);
    chk("t2_count", log_addr.size(), 4);
    chk("t2_w0", log_a(0), 17'h101);
    chk("t2_w1", log_a(1), 17'h102);
    chk("t2_w2", log_a(2), 17'h103);
    chk("t2_w3", log_a(3), 17'h100);
    chk("t2_b2b", log_c(3) - log_c(0), 3);
    @(negedge clk) chk("t2_total", bus.pixel_total, 32'd4);

    // backpressure: slot held by core 1, core 0 fills its FIFO
    tick(); frame_clear();
    bus.mem_w_ready = 1'b0;
    push(1, 17'h1F0, 24'hAAAAAA);
    tick(); idle();
    tick();
    push(0, 17'h200, 24'h10); tick();
    push(0, 17'h201, 24'h11); tick();
    push(0, 17'h202, 24'h12);
    @(negedge clk) chk("t3_full_early", bus.core_full[0], 1'b0);
    tick();
    push(0, 17'h203, 24'h13);
    @(negedge clk) chk("t3_full_rise", bus.core_full[0], 1'b1);
    tick();
    push(0, 17'h204, 24'h14);
    @(negedge clk) chk("t3_no_ovf_yet", bus.overflow[0], 1'b0);
    tick(); idle();
    @(negedge clk);
    chk("t3_ovf", bus.overflow[0], 1'b1);
    chk("t3_hold_valid", bus.mem_w_valid, 1'b1);
    chk("t3_hold_addr", bus.mem_w_addr, 17'h1F0);
    tick();
    bus.mem_w_ready = 1'b1;
    tick(8);
    chk("t3_count", log_addr.size(), 5);
    chk("t3_w0", log_a(0), 17'h1F0);
    for (int k = 0; k < 4; k++) chk("t3_order", log_a(k + 1), AW'(12'h200 + k));
    @(negedge clk) chk("t3_ovf_sticky", bus.overflow[0], 1'b1);

    // throughput: one push per cycle, one write per cycle
    tick(); frame_clear();
    seen_full1 = 1'b0;
    k0 = cyc;
    for (int k = 0; k < 20; k++) begin
      push(1, AW'(12'h300 + k), DW'(16'h5000 + k));
      tick();
    end
    idle();
    tick(5);
    chk("t4_count", log_addr.size(), 20);
    chk("t4_latency", log_c(0), k0 + 2);
    chk("t4_b2b", log_c(19) - log_c(0), 19);
    for (int k = 0; k < 20; k++) chk("t4_order", log_a(k), AW'(12'h300 + k));
    chk("t4_never_full", seen_full1, 1'b0);

    // frame completion at 8 commits
    tick(); frame_clear();
    done_cyc = -1;
    for (int i = 0; i < NC; i++) push(i, AW'(12'h400 + i), DW'(i));
    tick();
    for (int i = 0; i < NC; i++) push(i, AW'(12'h410 + i), DW'(i));
    tick(); idle();
    tick(12);
    chk("t5_count", log_addr.size(), 8);
    chk("t5_w3", log_a(3), 17'h400);
    chk("t5_w4", log_a(4), 17'h411);
    chk("t5_w7", log_a(7), 17'h410);
    chk("t5_done_cyc", done_cyc, log_c(7) + 2);
    @(negedge clk) chk("t5_total", bus.pixel_total, 32'd8);

    // frame_reset with a pending request and two queued entries
    tick();
    bus.mem_w_ready = 1'b0;
    push(0, 17'h500, 24'h1); tick();
    push(0, 17'h501, 24'h2); tick();
    push(0, 17'h502, 24'h3); tick(); idle();
    @(negedge clk) chk("t5_pending", bus.mem_w_valid, 1'b1);
    tick();
    bus.frame_reset = 1'b1;
    tick();
    bus.frame_reset = 1'b0;
    @(negedge clk);
    chk("t5_fr_valid", bus.mem_w_valid, 1'b0);
    chk("t5_fr_total", bus.pixel_total, 32'd0);
    chk("t5_fr_done", bus.frame_done, 1'b0);
    tick();
    bus.mem_w_ready = 1'b1;
    log_addr.delete();
    log_cyc.delete();
    tick(5);
    chk("t5_fifos_empty", log_addr.size(), 0);

    // asynchronous reset mid-stream
    for (int k = 0; k < 10; k++) begin
      push(3, AW'(12'h600 + k), DW'(k));
      tick();
    end
    idle();
    tick(4);
    bus.mem_w_ready = 1'b0;
    for (int k = 0; k < 6; k++) begin
      push(2, AW'(12'h700 + k), DW'(k));
      tick();
    end
    idle();
    tick(2);
    @(negedge clk);
    chk("t6_pre_valid", bus.mem_w_valid, 1'b1);
    chk("t6_pre_ovf", bus.overflow, 4'b0100);
    chk("t6_pre_total", bus.pixel_total, 32'd10);
    chk("t6_pre_done", bus.frame_done, 1'b1);
    @(posedge clk);
    #3 resetn = 1'b0;
    #1 chk_reset_vals("async");
    #10 resetn = 1'b1;
    tick(3);
    @(negedge clk) chk("t6_post_valid", bus.mem_w_valid, 1'b0);
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
